// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the top_mips debug controller.
// Host command bytes, the error byte and the HALT instruction word.
package mips_pkg;

    localparam logic [7:0]  CMD_LOAD  = 8'h4C;
    localparam logic [7:0]  CMD_CONT  = 8'h43;
    localparam logic [7:0]  CMD_STEP  = 8'h53;
    localparam logic [7:0]  CMD_DUMP  = 8'h52;
    localparam logic [7:0]  ERR_BYTE  = 8'hEE;
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_BYTE,
        S_LOAD_WRITE,
        S_ERR,
        S_ERR_WAIT,
        S_RUN,
        S_WD_ERR,
        S_WD_WAIT,
        S_STEP,
        S_DUMP_SET,
        S_DUMP_LATCH,
        S_DUMP_SEND,
        S_DUMP_PC,
        S_PC_WAIT
    } state_t;

endpackage

// File: rtl/dbg_word_tx.sv
// Serialises a word into bytes, LSB first, over a valid/ready byte stream.
// tx_data comes straight from a register, so tx_ready never reaches it combinationally.
module dbg_word_tx #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               single,
    input  logic [NB_DATA-1:0] word,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               done
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_CNT  = $clog2(N_BYTES);

    logic [NB_DATA-1:0] shreg;
    logic [NB_CNT-1:0]  cnt;
    logic               active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active && start) begin
                shreg  <= word;
                cnt    <= single ? '0 : NB_CNT'(N_BYTES - 1);
                active <= 1'b1;
            end else if (active && tx_ready) begin
                if (cnt == '0) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    shreg <= shreg >> NB_BYTE;
                    cnt   <= cnt - 1'b1;
                end
            end
        end
    end

    assign tx_valid = active;
    assign tx_data  = active ? shreg[NB_BYTE-1:0] : '0;

endmodule

// File: rtl/mips_debug_ctrl.sv
// Host-command debug controller for top_mips: program load, run/step and
// register+PC dump. Sole driver of the core's load, enable and debug-read ports.
module mips_debug_ctrl
    import mips_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int NB_ADDR   = 32,
    parameter int NB_REG    = 5,
    parameter int NB_BYTE   = 8,
    parameter int N_REGS    = 32,
    parameter int MEM_WORDS = 256,
    parameter int NB_WDOG   = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    input  logic               i_halt,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_data_read_debug,
    output logic               o_enable,
    output logic               o_write,
    output logic [NB_ADDR-1:0] o_address,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_REG-1:0]  o_address_read_debug,
    output logic               o_busy
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_BCNT = $clog2(N_BYTES);
    localparam int NB_PTR  = $clog2(MEM_WORDS);

    state_t              state, state_nx;
    logic [NB_DATA-1:0]  word;
    logic [NB_BCNT-1:0]  byte_cnt;
    logic [NB_PTR-1:0]   ptr;
    logic [NB_REG-1:0]   reg_idx;
    logic [NB_WDOG-1:0]  wdog;
    logic                wdog_full;
    logic                last_reg;

    logic                tx_start;
    logic                tx_single;
    logic [NB_DATA-1:0]  tx_word;
    logic                tx_done;

    assign wdog_full = &wdog;
    assign last_reg  = (reg_idx == NB_REG'(N_REGS - 1));

    always_comb begin
        state_nx  = state;
        tx_start  = 1'b0;
        tx_single = 1'b0;
        tx_word   = '0;
        case (state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: state_nx = S_LOAD_BYTE;
                        CMD_CONT: state_nx = S_RUN;
                        CMD_STEP: state_nx = S_STEP;
                        CMD_DUMP: state_nx = S_DUMP_SET;
                        default:  state_nx = S_IDLE;
                    endcase
                end
            end
            S_LOAD_BYTE: begin
                if (i_rx_valid && byte_cnt == NB_BCNT'(N_BYTES - 1))
                    state_nx = S_LOAD_WRITE;
            end
            S_LOAD_WRITE: begin
                if (word == NB_DATA'(HALT_WORD))
                    state_nx = S_IDLE;
                else if (ptr == NB_PTR'(MEM_WORDS - 1))
                    state_nx = S_ERR;
                else
                    state_nx = S_LOAD_BYTE;
            end
            S_ERR: begin
                tx_start  = 1'b1;
                tx_single = 1'b1;
                tx_word   = NB_DATA'(ERR_BYTE);
                state_nx  = S_ERR_WAIT;
            end
            S_ERR_WAIT: if (tx_done) state_nx = S_IDLE;
            // Halt wins over the watchdog when both hit in the same cycle.
            S_RUN: begin
                if (i_halt)
                    state_nx = S_DUMP_SET;
                else if (wdog_full)
                    state_nx = S_WD_ERR;
            end
            S_WD_ERR: begin
                tx_start  = 1'b1;
                tx_single = 1'b1;
                tx_word   = NB_DATA'(ERR_BYTE);
                state_nx  = S_WD_WAIT;
            end
            S_WD_WAIT:  if (tx_done) state_nx = S_DUMP_SET;
            S_STEP:     state_nx = S_DUMP_SET;
            S_DUMP_SET: state_nx = S_DUMP_LATCH;
            // Register file read data is valid one cycle after the address.
            S_DUMP_LATCH: begin
                tx_start = 1'b1;
                tx_word  = i_data_read_debug;
                state_nx = S_DUMP_SEND;
            end
            S_DUMP_SEND: begin
                if (tx_done)
                    state_nx = last_reg ? S_DUMP_PC : S_DUMP_SET;
            end
            S_DUMP_PC: begin
                tx_start = 1'b1;
                tx_word  = NB_DATA'(i_pc);
                state_nx = S_PC_WAIT;
            end
            S_PC_WAIT: if (tx_done) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= S_IDLE;
            word     <= '0;
            byte_cnt <= '0;
            ptr      <= '0;
            reg_idx  <= '0;
            wdog     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    byte_cnt <= '0;
                    reg_idx  <= '0;
                    wdog     <= '0;
                end
                S_LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        word     <= {i_rx_data, word[NB_DATA-1:NB_BYTE]};
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                S_LOAD_WRITE: begin
                    if (state_nx == S_LOAD_BYTE)
                        ptr <= ptr + 1'b1;
                    else
                        ptr <= '0;
                end
                S_RUN: if (o_enable) wdog <= wdog + 1'b1;
                S_DUMP_SEND: begin
                    if (tx_done && !last_reg)
                        reg_idx <= reg_idx + 1'b1;
                end
                S_PC_WAIT: if (tx_done) reg_idx <= '0;
                default: ;
            endcase
        end
    end

    dbg_word_tx #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_word_tx (
        .clk      (i_clk),
        .rst_n    (i_reset),
        .start    (tx_start),
        .single   (tx_single),
        .word     (tx_word),
        .tx_data  (o_tx_data),
        .tx_valid (o_tx_valid),
        .tx_ready (i_tx_ready),
        .done     (tx_done)
    );

    // Halt and watchdog gate enable in the same cycle so a halted core gets no extra cycle.
    assign o_enable = ((state == S_RUN) && !i_halt && !wdog_full) || (state == S_STEP);
    assign o_write  = (state == S_LOAD_WRITE);
    assign o_address     = o_write ? (NB_ADDR'(ptr) << 2) : '0;
    assign o_instruction = o_write ? word : '0;
    assign o_address_read_debug = reg_idx;
    assign o_busy   = (state != S_IDLE);

endmodule
